// File: rtl/aq_gemac_gmii_tx_framer_if.sv
// Upstream byte stream and GMII transmit side of the GEMAC transmit framer.
// The framer sits on the slave modport; the byte source sits on master.
interface aq_gemac_gmii_tx_framer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [7:0] bgmii_txd;
    logic       bgmii_txe;
    logic       bgmii_txer;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  bgmii_txd,
        input  bgmii_txe,
        input  bgmii_txer,
        input  busy,
        input  frame_done,
        input  underrun
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output bgmii_txd,
        output bgmii_txe,
        output bgmii_txer,
        output busy,
        output frame_done,
        output underrun
    );
endinterface

// File: rtl/aq_gemac_gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad to MIN_FRAME, CRC-32 FCS
// and inter-frame gap, with underrun abort. All GMII outputs and pulses are registered.
module aq_gemac_gmii_tx_framer #(
    parameter int MIN_FRAME = 60,
    parameter int IFG       = 12
) (
    input  logic                     tx_clk,
    input  logic                     rst,
    aq_gemac_gmii_tx_framer_if.slave bus
);

    localparam int CNT_W = $clog2(MIN_FRAME + 2);
    localparam int GEN_W = $clog2((IFG > 8) ? IFG : 8) + 1;

    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_FRAME);
    localparam logic [GEN_W-1:0] PRE_LAST = GEN_W'(7);
    localparam logic [GEN_W-1:0] FCS_LAST = GEN_W'(3);
    localparam logic [GEN_W-1:0] IFG_LAST = GEN_W'(IFG - 1);
    localparam logic [7:0]       PRE_BYTE = 8'h55;
    localparam logic [7:0]       SFD_BYTE = 8'hD5;
    localparam logic [31:0]      CRC_POLY = 32'hEDB88320;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG,
        S_DROP
    } state_t;

    state_t           state, state_n;
    logic [GEN_W-1:0] gcnt, gcnt_n;
    logic [CNT_W-1:0] bcnt, bcnt_n;
    logic [31:0]      crc, crc_n;
    logic             done_pend, done_pend_n;

    logic [7:0] txd_p0, txd_p1;
    logic       txe_p0, txe_p1;
    logic       txer_p0, txer_p1;
    logic       done_p0, done_p1;
    logic       urun_p0, urun_p1;

    // Reflected CRC-32, one byte per call, data LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // FCS is the complemented CRC, least significant byte first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx);
        logic [31:0] s;
        s = (~c) >> {idx, 3'b000};
        return s[7:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] b);
        return (b == MIN_C) ? b : b + CNT_W'(1);
    endfunction

    always_comb begin
        state_n     = state;
        gcnt_n      = gcnt;
        bcnt_n      = bcnt;
        crc_n       = crc;
        done_pend_n = done_pend;
        txd_p0      = 8'h00;
        txe_p0      = 1'b0;
        txer_p0     = 1'b0;
        done_p0     = 1'b0;
        urun_p0     = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_n = S_PRE;
                    gcnt_n  = GEN_W'(1);
                    txd_p0  = PRE_BYTE;
                    txe_p0  = 1'b1;
                end
            end

            S_PRE: begin
                txe_p0 = 1'b1;
                if (gcnt == PRE_LAST) begin
                    state_n     = S_SFD;
                    txd_p0      = SFD_BYTE;
                    gcnt_n      = '0;
                    bcnt_n      = '0;
                    crc_n       = 32'hFFFF_FFFF;
                    done_pend_n = 1'b0;
                end else begin
                    txd_p0 = PRE_BYTE;
                    gcnt_n = gcnt + GEN_W'(1);
                end
            end

            // The SFD cycle already offers in_ready, so its sample is the first payload byte.
            S_SFD, S_DATA: begin
                txe_p0 = 1'b1;
                if (bus.in_valid) begin
                    txd_p0 = bus.in_data;
                    crc_n  = crc_step(crc, bus.in_data);
                    bcnt_n = sat_inc(bcnt);
                    if (bus.in_last) begin
                        state_n = ((bcnt + CNT_W'(1)) < MIN_C) ? S_PAD : S_FCS;
                        gcnt_n  = '0;
                    end else begin
                        state_n = S_DATA;
                    end
                end else begin
                    txer_p0 = 1'b1;
                    urun_p0 = 1'b1;
                    state_n = S_DROP;
                end
            end

            S_PAD: begin
                txe_p0 = 1'b1;
                crc_n  = crc_step(crc, 8'h00);
                bcnt_n = sat_inc(bcnt);
                if ((bcnt + CNT_W'(1)) == MIN_C) begin
                    state_n = S_FCS;
                    gcnt_n  = '0;
                end
            end

            S_FCS: begin
                txe_p0 = 1'b1;
                txd_p0 = fcs_byte(crc, gcnt[1:0]);
                if (gcnt == FCS_LAST) begin
                    state_n     = S_IFG;
                    gcnt_n      = '0;
                    done_pend_n = 1'b1;
                end else begin
                    gcnt_n = gcnt + GEN_W'(1);
                end
            end

            // done_pend distinguishes a completed frame from a dropped one entering the gap.
            S_IFG: begin
                done_p0     = done_pend;
                done_pend_n = 1'b0;
                if (gcnt == IFG_LAST) begin
                    state_n = S_IDLE;
                    gcnt_n  = '0;
                end else begin
                    gcnt_n = gcnt + GEN_W'(1);
                end
            end

            S_DROP: begin
                if (bus.in_valid && bus.in_last) begin
                    state_n = S_IFG;
                    gcnt_n  = '0;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    // Output stage p1: registered GMII drive and status pulses.
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gcnt      <= '0;
            bcnt      <= '0;
            done_pend <= 1'b0;
            txd_p1    <= 8'h00;
            txe_p1    <= 1'b0;
            txer_p1   <= 1'b0;
            done_p1   <= 1'b0;
            urun_p1   <= 1'b0;
        end else begin
            state     <= state_n;
            gcnt      <= gcnt_n;
            bcnt      <= bcnt_n;
            done_pend <= done_pend_n;
            txd_p1    <= txd_p0;
            txe_p1    <= txe_p0;
            txer_p1   <= txer_p0;
            done_p1   <= done_p0;
            urun_p1   <= urun_p0;
        end
    end

    always_ff @(posedge tx_clk) begin
        crc <= crc_n;
    end

    assign bus.in_ready   = (state == S_SFD) || (state == S_DATA) || (state == S_DROP);
    assign bus.busy       = (state != S_IDLE);
    assign bus.bgmii_txd  = txd_p1;
    assign bus.bgmii_txe  = txe_p1;
    assign bus.bgmii_txer = txer_p1;
    assign bus.frame_done = done_p1;
    assign bus.underrun   = urun_p1;

endmodule

// File: tb/tb_aq_gemac_gmii_tx_framer.sv
// Bench for the GMII transmit framer: a per-cycle expected trace built from frame
// timing rules, plus an independent FCS residue and inter-frame gap check.
module tb_aq_gemac_gmii_tx_framer;

    localparam int MIN_FRAME = 60;
    localparam int IFG       = 12;
    localparam int MAXC      = 8000;
    localparam int MAXWAIT   = 400;

    logic tx_clk = 1'b0;
    logic rst    = 1'b1;

    aq_gemac_gmii_tx_framer_if bus ();

    aq_gemac_gmii_tx_framer #(
        .MIN_FRAME(MIN_FRAME),
        .IFG      (IFG)
    ) dut (
        .tx_clk(tx_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #4 tx_clk = ~tx_clk;

    int cyc = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    // Expected value of every output in the interval following edge n.
    logic [7:0] e_txd  [MAXC];
    bit         e_txe  [MAXC];
    bit         e_txer [MAXC];
    bit         e_rdy  [MAXC];
    bit         e_busy [MAXC];
    bit         e_done [MAXC];
    bit         e_urun [MAXC];

    logic [7:0] pl [256];
    int free_edge = 4;
    int n_checks  = 0;
    int n_fail    = 0;
    bit skip_res  = 1'b0;
    int last_gap  = 0;

    function automatic logic [31:0] crc_run(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic void put(input int t, input logic [7:0] b);
        e_txe[t] = 1'b1;
        e_txd[t] = b;
    endfunction

    // Lay out the whole expected trace of a frame whose start is first requested at edge req.
    function automatic void plan_frame(input int req, input int n, input int u, output int k);
        int L;
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0] b;
        k = (req > free_edge) ? req : free_edge;
        if (k + n + MIN_FRAME + 40 >= MAXC) begin
            $display("FAIL trace_overflow: start edge %0d beyond budget %0d", k, MAXC);
            $fatal(1);
        end
        for (int t = 0; t < 7; t++) put(k + t, 8'h55);
        put(k + 7, 8'hD5);
        if (u == 0) begin
            L = (n < MIN_FRAME) ? MIN_FRAME : n;
            c = 32'hFFFF_FFFF;
            for (int j = 0; j < L; j++) begin
                b = (j < n) ? pl[j] : 8'h00;
                put(k + 8 + j, b);
                c = crc_run(c, b);
            end
            fcs = ~c;
            for (int i = 0; i < 4; i++) put(k + 8 + L + i, fcs[8*i +: 8]);
            e_done[k + 12 + L] = 1'b1;
            for (int t = k + 7; t <= k + 6 + n; t++) e_rdy[t] = 1'b1;
            for (int t = k; t <= k + 22 + L; t++) e_busy[t] = 1'b1;
            free_edge = k + 24 + L;
        end else begin
            for (int j = 0; j < u; j++) put(k + 8 + j, pl[j]);
            put(k + 8 + u, 8'h00);
            e_txer[k + 8 + u] = 1'b1;
            e_urun[k + 8 + u] = 1'b1;
            for (int t = k + 7; t <= k + 7 + n; t++) e_rdy[t] = 1'b1;
            for (int t = k; t <= k + 19 + n; t++) e_busy[t] = 1'b1;
            free_edge = k + 21 + n;
        end
    endfunction

    function automatic void clear_from(input int e);
        for (int t = e; t < MAXC; t++) begin
            e_txd[t] = 8'h00; e_txe[t] = 1'b0; e_txer[t] = 1'b0; e_rdy[t] = 1'b0;
            e_busy[t] = 1'b0; e_done[t] = 1'b0; e_urun[t] = 1'b0;
        end
        free_edge = e + 1;
    endfunction

    // Called just after a rising edge; offers n bytes, withholding valid once after byte u (u>0).
    task automatic drive_frame(input int n, input int u, output int k);
        int idx;
        int it;
        bit acc;
        bit gap;
        plan_frame(cyc + 1, n, u, k);
        idx = 0; it = 0; gap = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = pl[0];
        bus.in_last  = (n == 1);
        while (idx < n) begin
            @(negedge tx_clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge tx_clk);
            #1;
            it++;
            if (it > MAXWAIT) begin
                n_checks++;
                n_fail++;
                $display("FAIL drive_timeout: accepted %0d of %0d bytes", idx, n);
                break;
            end
            if (acc) begin
                idx++;
                if (u != 0 && idx == u && !gap) begin
                    gap = 1'b1;
                    bus.in_valid = 1'b0;
                end
            end else if (!bus.in_valid) begin
                bus.in_valid = 1'b1;
            end
            if (idx < n) begin
                bus.in_data = pl[idx];
                bus.in_last = (idx == n - 1);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
    endtask

    // Per-cycle comparison against the expected trace.
    always @(negedge tx_clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            logic [5:0] act;
            logic [5:0] exp_v;
            act   = {bus.bgmii_txe, bus.bgmii_txer, bus.in_ready, bus.busy, bus.frame_done, bus.underrun};
            exp_v = {e_txe[cyc], e_txer[cyc], e_rdy[cyc], e_busy[cyc], e_done[cyc], e_urun[cyc]};
            n_checks++;
            if (act !== exp_v || (e_txe[cyc] && bus.bgmii_txd !== e_txd[cyc])) begin
                n_fail++;
                $display("FAIL trace cyc=%0d {txe,txer,rdy,busy,done,urun} got %b want %b txd got %h want %h",
                         cyc, act, exp_v, bus.bgmii_txd, e_txd[cyc]);
            end
            if (cyc == 3) begin
                n_checks++;
                if (bus.bgmii_txe !== 1'b0 || bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_hold: txe=%b busy=%b want 0 0", bus.bgmii_txe, bus.busy);
                end
            end
            if (cyc == 4) begin
                n_checks++;
                if (bus.bgmii_txe !== 1'b1 || bus.bgmii_txd !== 8'h55) begin
                    n_fail++;
                    $display("FAIL first_preamble: txe=%b txd=%h want 1 55", bus.bgmii_txe, bus.bgmii_txd);
                end
            end
        end
    end

    // Independent frame collector: preamble shape, FCS residue, gap length.
    logic [7:0] fb[$];
    bit ferr = 1'b0;
    bit prev_txe = 1'b0;
    int gap_run = 0;
    always @(negedge tx_clk) begin
        if (cyc >= 1) begin
            if (bus.bgmii_txe) begin
                if (!prev_txe) last_gap = gap_run;
                fb.push_back(bus.bgmii_txd);
                if (bus.bgmii_txer) ferr = 1'b1;
            end else begin
                if (prev_txe) begin
                    if (!ferr && !skip_res) begin
                        logic [31:0] c;
                        bit pre_ok;
                        pre_ok = (fb.size() >= 8 + MIN_FRAME + 4);
                        for (int i = 0; i < 7 && pre_ok; i++) if (fb[i] !== 8'h55) pre_ok = 1'b0;
                        if (pre_ok && fb[7] !== 8'hD5) pre_ok = 1'b0;
                        n_checks++;
                        if (!pre_ok) begin
                            n_fail++;
                            $display("FAIL frame_shape: got %0d bytes, preamble/SFD wrong or frame short", fb.size());
                        end
                        c = 32'hFFFF_FFFF;
                        for (int i = 8; i < fb.size(); i++) c = crc_run(c, fb[i]);
                        n_checks++;
                        if (~c !== 32'h2144DF1C) begin
                            n_fail++;
                            $display("FAIL fcs_residue: got %h want 2144df1c", ~c);
                        end
                    end
                    skip_res = 1'b0;
                    ferr = 1'b0;
                    fb.delete();
                    gap_run = 0;
                end
                gap_run++;
            end
            prev_txe = bus.bgmii_txe;
        end
    end

    initial begin
        int k;
        int n;
        int u;
        logic [31:0] c;
        logic [7:0] chk [9];

        // Pin the reference CRC against the well-known check value of "123456789".
        for (int i = 0; i < 9; i++) chk[i] = 8'h31 + 8'(i);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) c = crc_run(c, chk[i]);
        n_checks++;
        if (~c !== 32'hCBF43926) begin
            n_fail++;
            $display("FAIL crc_model_pin: got %h want cbf43926", ~c);
        end

        for (int i = 0; i < 60; i++) pl[i] = 8'(i);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge tx_clk);
        #1;
        rst = 1'b0;
        drive_frame(60, 0, k);

        // Short frame, offered immediately: back-to-back with the minimum frame.
        fill(14);
        drive_frame(14, 0, k);
        n_checks++;
        if (last_gap != IFG) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d idle cycles want %0d", last_gap, IFG);
        end

        fill(40);
        drive_frame(40, 20, k);

        repeat (20) begin
            n = $urandom_range(1, 100);
            u = (n > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : 0;
            fill(n);
            repeat ($urandom_range(0, 5)) begin
                @(posedge tx_clk);
                #1;
            end
            drive_frame(n, u, k);
        end

        // Reset landing on FCS byte 2 of a padded frame.
        fill(30);
        drive_frame(30, 0, k);
        while (cyc < k + 10 + MIN_FRAME) begin
            @(posedge tx_clk);
            #1;
        end
        skip_res = 1'b1;
        rst = 1'b1;
        @(posedge tx_clk);
        #1;
        rst = 1'b0;
        clear_from(k + 11 + MIN_FRAME);

        fill(64);
        drive_frame(64, 0, k);
        while (cyc < free_edge + 3) begin
            @(posedge tx_clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aq_gemac_gmii_tx_framer.md
# aq_gemac_gmii_tx_framer

Transmit framer for the GEMAC. It turns a byte stream of frame contents (DA through payload) into a complete GMII transmit sequence: preamble, SFD, payload, zero padding to minimum length, CRC-32 FCS, and the inter-frame gap. It sits directly upstream of the GMII I/O buffer and drives its `bgmii_txd`/`bgmii_txe`/`bgmii_txer` inputs in the `tx_clk` domain.

## Interface
Clocking and reset: one clock, `tx_clk`. Reset `rst` is synchronous and active-high.

Parameters
- `MIN_FRAME`, default 60: minimum frame length in bytes, DA through pad, excluding FCS.
- `IFG`, default 12: inter-frame gap in `tx_clk` cycles.

Ports
- `tx_clk`  in  1  transmit clock, 125 MHz in GMII mode.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  upstream byte.
- `in_last`  in  1  marks the final payload byte of the frame.
- `in_ready`  out  1  framer accepts `in_data` this cycle.
- `bgmii_txd`  out  8  GMII transmit data.
- `bgmii_txe`  out  1  GMII transmit enable.
- `bgmii_txer`  out  1  GMII transmit error.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse after the last FCS byte.
- `underrun`  out  1  one-cycle pulse when the frame is aborted for underrun.

## Operation
- All GMII outputs and the pulses are registered. Reset value of every output is 0.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP.
- IDLE:
  - `in_ready`=0.
  - `in_valid`=1 starts a frame: go to PRE. The byte is not consumed.
- PRE: 7 cycles with `txd`=0x55 and `txe`=1, then go to SFD.
- SFD: one cycle with `txd`=0xD5.
  - `in_ready`=1 in the SFD cycle and in every DATA cycle.
- DATA: a byte accepted (`in_valid & in_ready`) at edge e appears on `txd` with `txe`=1 after edge e.
  - Accepted bytes enter the CRC and increment a byte counter that saturates at `MIN_FRAME`.
  - `in_last` accepted with count+1 < `MIN_FRAME`: go to PAD.
  - Otherwise `in_last` accepted: go to FCS.
- PAD:
  - `in_ready`=0.
  - Emit 0x00 bytes, included in the CRC, until the total reaches `MIN_FRAME`, then go to FCS.
- FCS: 4 bytes of the complemented CRC, LSB byte first, then go to IFG.
  - `frame_done` pulses coincident with the first IFG cycle.
- CRC rules:
  - IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - The CRC is reinitialised at SFD.
  - It is updated one byte per cycle, LSB first.
- IFG:
  - `txe`=0 and `txd`=0x00 for `IFG` cycles, then go to IDLE.
  - `in_ready`=0 throughout.
- Underrun (DATA state with `in_ready`=1 and `in_valid`=0):
  - Output that cycle: `txe`=1, `txer`=1, `txd`=0x00.
  - `underrun` pulses.
  - Go to DROP.
- DROP:
  - `txe`=0 and `in_ready`=1.
  - Discard bytes until `in_last` is accepted, then go to IFG.
  - No FCS and no `frame_done`.
- `txer` is 0 except in the underrun cycle.
- Maximum frame length is not enforced; the counter only governs padding.

## Timing
- Start latency: `in_valid` sampled high in IDLE at edge k gives:
  - `txe`=1 and `txd`=0x55 from k+1 to k+7.
  - 0xD5 at k+8.
  - First payload byte at k+9, accepted at edge k+8.
- A frame of N ≥ `MIN_FRAME` bytes occupies `txe` for 8+N+4 cycles.
- A frame of N < `MIN_FRAME` bytes occupies `txe` for 8+`MIN_FRAME`+4 cycles.
- Back-to-back frames: earliest next start sample is the first IDLE cycle, giving ≥ `IFG` idle cycles between frames.
- Reset mid-frame: on the edge sampling `rst`=1, all outputs go to 0 and the state goes to IDLE. The frame is truncated with no FCS; upstream is responsible for flushing.
- Single-byte payload (`in_last` on the first byte) is legal and is padded.

## Test plan
- Reset: hold `rst` 3 cycles with `in_valid`=1 → all outputs 0. The first start is sampled only after `rst` falls; preamble appears exactly 1 cycle later.
- Minimum frame, payload 0x00..0x3B (60 bytes):
  - `txd` sequence is 7×0x55, 0xD5, 60 data bytes, 4 FCS bytes; `txe` high for 72 cycles.
  - CRC-32 recomputed over data+FCS by the bench gives residue 0x2144DF1C.
  - `frame_done` pulses once.
- Short frame, 14-byte payload: 46 bytes of 0x00 pad follow; `in_ready` low during pad; FCS residue check passes.
- Back-to-back frames, upstream always valid: exactly 12 cycles with `txe`=0 between the last FCS byte and the next preamble.
- Underrun after 20 bytes (`in_valid`=0 for one DATA cycle):
  - One cycle with `txe`=1, `txer`=1; `underrun` pulses.
  - Remaining bytes through `in_last` are consumed with `txe`=0.
  - IFG follows; no `frame_done`.
- Reset asserted during FCS byte 2: next cycle `txe`=0, `busy`=0; a following frame is transmitted with a correct FCS.
